// File: rtl/peak_window_detector.sv
// Peak-magnitude detector: reports the largest |sample - MIDSCALE| over each
// window of WINDOW accepted samples, with bad-sample and overrun flags.
module peak_window_detector #(
  parameter int DATA_WIDTH = 12,
  parameter int WINDOW     = 64,
  parameter int MIDSCALE   = 2048
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] ast_sink_data,
  input  logic                  ast_sink_valid,
  input  logic [1:0]            ast_sink_error,
  output logic [DATA_WIDTH-1:0] ast_source_data,
  output logic                  ast_source_valid,
  output logic [1:0]            ast_source_error,
  input  logic                  ast_source_ready
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    flush;
  logic [CNT_W-1:0]        sample_count;
  logic [DATA_WIDTH-1:0]   peak;
  logic                    bad_flag;
  logic                    sample_ok;
  logic                    sample_bad;
  logic [DATA_WIDTH-1:0]   mag_p0;

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] d);
    logic signed [DATA_WIDTH:0] mid;
    logic signed [DATA_WIDTH:0] diff;
    mid  = (DATA_WIDTH + 1)'(MIDSCALE);
    diff = $signed({1'b0, d}) - mid;
    if (diff < 0) diff = -diff;
    return diff[DATA_WIDTH-1:0];
  endfunction

  assign mag_p0     = magnitude(ast_sink_data);
  assign sample_ok  = ast_sink_valid && (ast_sink_error == 2'b00);
  assign sample_bad = ast_sink_valid && (ast_sink_error != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (ast_sink_valid && (sample_count == LAST_CNT)) state_nxt = FLUSH;
        FLUSH:   state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    flush = en && (state == FLUSH);
  end

  // Window accumulation; a sample arriving in FLUSH seeds the next window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_count <= '0;
      peak         <= '0;
      bad_flag     <= 1'b0;
    end else if (!en) begin
      sample_count <= '0;
      peak         <= '0;
      bad_flag     <= 1'b0;
    end else if (flush) begin
      sample_count <= {{(CNT_W-1){1'b0}}, ast_sink_valid};
      peak         <= sample_ok ? mag_p0 : '0;
      bad_flag     <= sample_bad;
    end else if (ast_sink_valid) begin
      sample_count <= sample_count + 1'b1;
      if (sample_ok && (mag_p0 > peak)) peak <= mag_p0;
      if (sample_bad) bad_flag <= 1'b1;
    end
  end

  // Result register; bit1 records that an unread result was replaced
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ast_source_data  <= '0;
      ast_source_error <= 2'b00;
      ast_source_valid <= 1'b0;
    end else if (flush) begin
      ast_source_data  <= peak;
      ast_source_error <= {ast_source_valid && !ast_source_ready, bad_flag};
      ast_source_valid <= 1'b1;
    end else if (ast_source_valid && ast_source_ready) begin
      ast_source_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_window_detector.sv
// Randomized and directed bench for peak_window_detector (WINDOW=4) with a
// window-level reference model feeding a scoreboard queue.
module tb_peak_window_detector;

  localparam int DW  = 12;
  localparam int WIN = 4;
  localparam int MID = 2048;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] ast_sink_data = '0;
  logic          ast_sink_valid = 1'b0;
  logic [1:0]    ast_sink_error = 2'b00;
  logic [DW-1:0] ast_source_data;
  logic          ast_source_valid;
  logic [1:0]    ast_source_error;
  logic          ast_source_ready = 1'b0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    err;
  } res_t;

  int   n_checks = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   win_d[$];
  int   win_e[$];
  bit   flush_pend = 1'b0;
  int   flush_peak = 0;
  bit   flush_bad = 1'b0;
  bit   en_cfg = 1'b0;
  bit   rdy_cfg = 1'b0;

  peak_window_detector #(.DATA_WIDTH(DW), .WINDOW(WIN), .MIDSCALE(MID)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .en               (en),
    .ast_sink_data    (ast_sink_data),
    .ast_sink_valid   (ast_sink_valid),
    .ast_sink_error   (ast_sink_error),
    .ast_source_data  (ast_source_data),
    .ast_source_valid (ast_source_valid),
    .ast_source_error (ast_source_error),
    .ast_source_ready (ast_source_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string name, input int idx, input int d, input int e);
    if (idx >= got_q.size()) begin
      check({name, "_present"}, got_q.size(), idx + 1);
      return;
    end
    check({name, "_data"}, int'(got_q[idx].data), d);
    check({name, "_err"}, int'(got_q[idx].err), e);
  endtask

  // Window-level reference: collect WIN samples, then the result appears
  // one cycle later, replacing any unread result.
  task automatic model_step();
    res_t r;
    int   m;
    bit   ovw;
    if (!reset_n) begin
      win_d.delete();
      win_e.delete();
      exp_q.delete();
      flush_pend = 1'b0;
      return;
    end
    if (flush_pend && en) begin
      ovw = (exp_q.size() != 0);
      exp_q.delete();
      r.data = DW'(flush_peak);
      r.err  = {ovw, flush_bad};
      exp_q.push_back(r);
    end
    flush_pend = 1'b0;
    if (!en) begin
      win_d.delete();
      win_e.delete();
    end else if (ast_sink_valid) begin
      win_d.push_back(int'(ast_sink_data));
      win_e.push_back(int'(ast_sink_error));
      if (win_d.size() == WIN) begin
        flush_peak = 0;
        flush_bad  = 1'b0;
        foreach (win_d[i]) begin
          if (win_e[i] != 0) begin
            flush_bad = 1'b1;
          end else begin
            m = win_d[i] - MID;
            if (m < 0) m = -m;
            if (m > flush_peak) flush_peak = m;
          end
        end
        flush_pend = 1'b1;
        win_d.delete();
        win_e.delete();
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    res_t r;
    if (reset_n) begin
      check("valid", int'(ast_source_valid), int'(exp_q.size() != 0));
      if (ast_source_valid && exp_q.size() != 0) begin
        check("data", int'(ast_source_data), int'(exp_q[0].data));
        check("error", int'(ast_source_error), int'(exp_q[0].err));
        if (ast_source_ready) exp_q.delete(0);
      end
      if (ast_source_valid && ast_source_ready) begin
        r = {ast_source_data, ast_source_error};
        got_q.push_back(r);
      end
    end
  end

  task automatic step(input bit v, input int d, input int e);
    @(posedge clk);
    #1;
    en               = en_cfg;
    ast_source_ready = rdy_cfg;
    ast_sink_valid   = v;
    ast_sink_data    = DW'(d);
    ast_sink_error   = 2'(e);
    @(negedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  task automatic burst(input int d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, d, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    reset_n        = 1'b0;
    ast_sink_valid = 1'b0;
    #1;
    check("rst_valid", int'(ast_source_valid), 0);
    check("rst_data", int'(ast_source_data), 0);
    check("rst_error", int'(ast_source_error), 0);
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    model_step();
  endtask

  initial begin
    int base;
    #1 reset_n = 1'b0;
    #2;
    check("init_valid", int'(ast_source_valid), 0);
    check("init_data", int'(ast_source_data), 0);
    check("init_error", int'(ast_source_error), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    en_cfg = 1'b1;

    // Basic window, ready held high
    rdy_cfg = 1'b1;
    base = got_q.size();
    step(1'b1, 2048, 0); step(1'b1, 2100, 0); step(1'b1, 1900, 0); step(1'b1, 2050, 0);
    idle(4);
    check("basic_count", got_q.size() - base, 1);
    check_res("basic", base, 148, 0);

    // Magnitude extremes
    base = got_q.size();
    step(1'b1, 0, 0); burst(2048, 3);
    idle(4);
    burst(4095, 4);
    idle(4);
    check_res("neg_full", base, 2048, 0);
    check_res("pos_full", base + 1, 2047, 0);

    // Bad sample excluded from peak but flagged
    base = got_q.size();
    step(1'b1, 2060, 0); step(1'b1, 0, 1); step(1'b1, 2060, 0); step(1'b1, 2060, 0);
    idle(4);
    check_res("bad", base, 12, 1);

    // All-bad window
    base = got_q.size();
    for (int i = 0; i < WIN; i++) step(1'b1, 100 * i, 3);
    idle(4);
    check_res("allbad", base, 0, 1);

    // Overwrite of an unread result
    rdy_cfg = 1'b0;
    base = got_q.size();
    burst(2058, 4); burst(2068, 4);
    idle(3);
    check("ovw_held", got_q.size() - base, 0);
    rdy_cfg = 1'b1;
    idle(1);
    rdy_cfg = 1'b0;
    idle(2);
    check("ovw_count", got_q.size() - base, 1);
    check_res("ovw", base, 20, 2);

    // Handshake coinciding with load; back-to-back sample in FLUSH
    rdy_cfg = 1'b1;
    idle(1);
    rdy_cfg = 1'b0;
    base = got_q.size();
    burst(2058, 4);
    idle(2);
    burst(2070, 4);
    rdy_cfg = 1'b1;
    step(1'b1, 2053, 0);
    burst(2049, 3);
    idle(4);
    check("coin_count", got_q.size() - base, 3);
    check_res("coin_a", base, 10, 0);
    check_res("coin_b", base + 1, 22, 0);
    check_res("coin_c", base + 2, 5, 0);

    // Enable drop discards the partial window
    base = got_q.size();
    burst(2148, 3);
    en_cfg = 1'b0;
    idle(2);
    en_cfg = 1'b1;
    burst(2058, 4);
    idle(4);
    check("en_count", got_q.size() - base, 1);
    check_res("en", base, 10, 0);

    // Reset mid-window with a result pending
    rdy_cfg = 1'b0;
    burst(2058, 4);
    idle(3);
    burst(2148, 2);
    reset_pulse();
    rdy_cfg = 1'b1;
    base = got_q.size();
    burst(2058, 2);
    idle(4);
    check("rst_partial", got_q.size() - base, 0);
    burst(2060, 2);
    idle(4);
    check("rst_count", got_q.size() - base, 1);
    check_res("rst", base, 12, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rdy_cfg = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    rdy_cfg = 1'b1;
    idle(6);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
